vector_alu_sequencer: RTL and testbench
=======================================

VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 32: element width in bits.
REQ-002 SHALL have parameter LANES, default 4: elements per vector, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: a vector operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 SHALL have port op_a, input, LANES*N bits: operand A vector; lane i occupies bits [i*N +: N].
REQ-008 SHALL have port op_b, input, LANES*N bits: operand B vector, packed the same way as op_a.
REQ-009 SHALL have port control, input, 2 bits: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-010 SHALL have port out_valid, output, 1 bit: the result vector is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port result, output, LANES*N bits: the result vector, packed the same way as op_a.
REQ-013 SHALL have port lane_flags, output, LANES*4 bits: per-lane flags; bit 0 overflow, bit 1 carry, bit 2 zero, bit 3 negative.
REQ-014 SHALL have port flags, output, 4 bits: vector summary flags, using the same bit order as lane_flags.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-016 SHALL drive in_ready = (state == IDLE) and out_valid = (state == DONE), both purely from state.
REQ-017 SHALL, in IDLE with in_valid=1 at a clock edge, latch op_a, op_b and control, clear the lane counter, clear result, lane_flags and flags, and enter EXEC.
REQ-018 SHALL, in EXEC, present lane[cnt] of the latched operands and latched control to one N-bit ALU each cycle.
REQ-019 SHALL, at each EXEC edge, register that ALU output into result lane cnt and its flags into lane_flags lane cnt, then increment cnt.
REQ-020 SHALL take lane overflow, carry and negative flags from the ALU.
REQ-021 SHALL compute the lane zero flag locally as (full N-bit lane result == 0).
REQ-022 SHALL force lane carry and overflow to 0 for AND and OR.
REQ-023 SHALL set flags[0], flags[1] and flags[3] to the OR across lanes, and flags[2] to the AND across lanes (all lanes zero); all are final when DONE is entered.
REQ-024 SHALL move from EXEC to DONE on the edge that processes lane LANES-1; out_valid first rises exactly LANES cycles after the accepting edge.
REQ-025 SHALL, in DONE, hold result, lane_flags and flags stable until out_valid and out_ready are both 1, then return to IDLE on that edge.
REQ-026 SHALL ignore in_valid, op_a, op_b and control while in EXEC or DONE; the latched copies alone are used.
REQ-027 SHALL leave result, lane_flags and flags holding their last values in IDLE until the next accept.
REQ-028 SHALL give the lane counter clog2(LANES) bits, with no wrap-around beyond LANES-1.

Reset
REQ-029 SHALL, while rst_n=0 and regardless of clk, force state=IDLE, cnt=0 and result, lane_flags, flags and all latched operands to 0; as a result out_valid=0 and in_ready=1.
REQ-030 SHALL, on reset during EXEC or DONE, abandon the operation with no partial result visible afterward.

Structure
REQ-031 SHALL place the following in shared package vec_alu_pkg: the state enum, the control opcode constants (ADD, SUB, AND, OR), the flag bit index constants (FLAG_OVF=0, FLAG_CARRY=1, FLAG_ZERO=2, FLAG_NEG=3) and the LANES default.
REQ-032 SHALL instantiate exactly one ALU sub-module (existing module ALU, N-bit, combinational).

Verification
REQ-033 SHALL cover: ADD, A={1,2,3,4}, B={10,20,30,40} -> result {11,22,33,44}, out_valid 4 cycles after accept, flags=4'b0000.
REQ-034 SHALL cover: SUB with every lane A=5, B=5 -> every lane result 0 with lane_flags 4'b0110, and flags=4'b0110.
REQ-035 SHALL cover: ADD with lane2 A=0x7FFFFFFF, B=1 and other lanes 0+0 -> lane2 result 0x80000000 with lane_flags 4'b1001, other lanes lane_flags 4'b0100, flags=4'b1001.
REQ-036 SHALL cover: AND, all lanes A=0xF0F0F0F0, B=0xFF00FF00 -> every lane 0xF000F000, flags=4'b1000.
REQ-037 SHALL cover: out_ready=0 for 5 cycles in DONE while new in_valid pulses are driven -> result held, in_ready=0, pulses ignored; raising out_ready returns to IDLE next edge with in_ready=1.
REQ-038 SHALL cover: rst_n asserted after 2 EXEC edges -> immediately out_valid=0, in_ready=1, result=0; a new operation then completes normally.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU sequencer: FSM states, opcodes and flag bit positions.
package vec_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int FLAG_OVF   = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_NEG   = 3;

  localparam int LANES_DEFAULT = 4;

endpackage

// File: rtl/ALU.sv
// N-bit combinational ALU: add, subtract (carry = no borrow), bitwise AND and OR.
module ALU
  import vec_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] y,
  output logic         carry,
  output logic         overflow,
  output logic         negative
);

  logic         sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    sub      = (op == OP_SUB);
    b_eff    = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    y        = sum[N-1:0];
    carry    = sum[N];
    overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
    case (op)
      OP_AND: begin
        y        = a & b;
        carry    = 1'b0;
        overflow = 1'b0;
      end
      OP_OR: begin
        y        = a | b;
        carry    = 1'b0;
        overflow = 1'b0;
      end
      default: ;
    endcase
    negative = y[N-1];
  end

endmodule

// File: rtl/vector_alu_sequencer.sv
// Applies one opcode lane by lane to two latched vectors through a single shared ALU,
// accumulating per-lane and summary flags, with a valid/ready handshake on both sides.
module vector_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = LANES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] op_a,
  input  logic [LANES*N-1:0] op_b,
  input  logic [1:0]         control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] result,
  output logic [LANES*4-1:0] lane_flags,
  output logic [3:0]         flags
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LANES*N-1:0] a_lat;
  logic [LANES*N-1:0] b_lat;
  logic [1:0]         ctrl_lat;

  logic [N-1:0] lane_a;
  logic [N-1:0] lane_b;
  logic [N-1:0] lane_y;
  logic         alu_carry;
  logic         alu_ovf;
  logic         alu_neg;
  logic         logic_op;
  logic [3:0]   lane_f;

  assign lane_a    = a_lat[cnt*N +: N];
  assign lane_b    = b_lat[cnt*N +: N];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  ALU #(.N(N)) u_alu (
    .a        (lane_a),
    .b        (lane_b),
    .op       (ctrl_lat),
    .y        (lane_y),
    .carry    (alu_carry),
    .overflow (alu_ovf),
    .negative (alu_neg)
  );

  always_comb begin
    logic_op              = (ctrl_lat == OP_AND) || (ctrl_lat == OP_OR);
    lane_f                = '0;
    lane_f[FLAG_OVF]      = alu_ovf & ~logic_op;
    lane_f[FLAG_CARRY]    = alu_carry & ~logic_op;
    lane_f[FLAG_ZERO]     = (lane_y == '0);
    lane_f[FLAG_NEG]      = alu_neg;
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values;
  // the operand latches are ordinary flops and are reset too, so no stale operands survive a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      ctrl_lat   <= '0;
      result     <= '0;
      lane_flags <= '0;
      flags      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat      <= op_a;
            b_lat      <= op_b;
            ctrl_lat   <= control;
            cnt        <= '0;
            result     <= '0;
            lane_flags <= '0;
            flags      <= '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result[cnt*N +: N]     <= lane_y;
          lane_flags[cnt*4 +: 4] <= lane_f;
          flags[FLAG_OVF]        <= flags[FLAG_OVF] | lane_f[FLAG_OVF];
          flags[FLAG_CARRY]      <= flags[FLAG_CARRY] | lane_f[FLAG_CARRY];
          flags[FLAG_NEG]        <= flags[FLAG_NEG] | lane_f[FLAG_NEG];
          // All-lanes-zero starts from the first lane rather than from the cleared value.
          flags[FLAG_ZERO]       <= (cnt == '0) ? lane_f[FLAG_ZERO]
                                                : (flags[FLAG_ZERO] & lane_f[FLAG_ZERO]);
          if (cnt == LAST_LANE) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer: arithmetic reference model plus literal spot checks.
module tb_vector_alu_sequencer;

  localparam int N     = 32;
  localparam int LANES = 4;
  localparam int W     = LANES * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [LANES*4-1:0] lane_flags;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]       exp_result;
  logic [LANES*4-1:0] exp_lflags;
  logic [3:0]         exp_flags;
  logic               exp_live = 1'b0;

  vector_alu_sequencer #(.N(N), .LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .control    (control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .lane_flags (lane_flags),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference model: plain wide arithmetic on each lane, flags from value ranges.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c);
    logic [31:0] ua, ub, r;
    longint sa, sb, sres;
    longint unsigned wide;
    logic cy, ov;
    logic any_ov, any_cy, any_ng, all_z;
    any_ov = 0; any_cy = 0; any_ng = 0; all_z = 1;
    exp_result = '0;
    exp_lflags = '0;
    for (int i = 0; i < LANES; i++) begin
      ua = a[i*N +: N];
      ub = b[i*N +: N];
      sa = longint'($signed(ua));
      sb = longint'($signed(ub));
      cy = 0; ov = 0; sres = 0;
      case (c)
        2'b00: begin
          wide = longint'(ua) + longint'(ub);
          r    = wide[31:0];
          cy   = wide > 64'hFFFF_FFFF;
          sres = sa + sb;
        end
        2'b01: begin
          r    = ua - ub;
          cy   = ua >= ub;
          sres = sa - sb;
        end
        2'b10: r = ua & ub;
        default: r = ua | ub;
      endcase
      if (c[1] == 1'b0) ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      exp_result[i*N +: N] = r;
      exp_lflags[i*4 +: 4] = {r[31], r == 32'd0, cy, ov};
      any_ov |= ov; any_cy |= cy; any_ng |= r[31]; all_z &= (r == 32'd0);
    end
    exp_flags = {any_ng, all_z, any_cy, any_ov};
  endtask

  // Compare process: whenever a result is offered it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_live) check("unexpected_out_valid", W'(out_valid), W'(0));
      else begin
        check("model_result", result, exp_result);
        check("model_lane_flags", W'(lane_flags), W'(exp_lflags));
        check("model_flags", W'(flags), W'(exp_flags));
      end
    end
  end

  // Offer one operation and wait for DONE; returns cycles from accept edge to out_valid.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!in_ready) check("in_ready_timeout", W'(in_ready), W'(1));
    model(a, b, c);
    exp_live = 1'b1;
    op_a = a; op_b = b; control = c; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = '0; op_b = '0; control = 2'b00;
    check("in_ready_low_in_exec", W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < LANES + 8) begin @(negedge clk); lat++; end
    if (!out_valid) check("out_valid_timeout", W'(out_valid), W'(1));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_live  = 1'b0;
    check("idle_in_ready", W'(in_ready), W'(1));
    check("idle_out_valid", W'(out_valid), W'(0));
    check("idle_result_held", result, exp_result);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; control = 2'b00;
    #12;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, '0);
    check("rst_lane_flags", W'(lane_flags), '0);
    check("rst_flags", W'(flags), '0);
    @(negedge clk); rst_n = 1'b1;

    // ADD small values
    issue(pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 2'b00, lat);
    check("add_latency", W'(lat), W'(LANES));
    check("add_result_lit", result, pack4(11, 22, 33, 44));
    check("add_flags_lit", W'(flags), W'(4'b0000));
    consume();

    // SUB equal lanes -> zero with carry (no borrow)
    issue(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 2'b01, lat);
    check("sub_zero_result_lit", result, '0);
    check("sub_zero_lflags_lit", W'(lane_flags), W'(16'h6666));
    check("sub_zero_flags_lit", W'(flags), W'(4'b0110));
    consume();

    // ADD signed overflow in lane 2
    issue(pack4(0, 0, 32'h7FFF_FFFF, 0), pack4(0, 0, 1, 0), 2'b00, lat);
    check("ovf_lane2_lit", W'(result[2*N +: N]), W'(32'h8000_0000));
    check("ovf_lflags_lit", W'(lane_flags), W'(16'h4944));
    check("ovf_flags_lit", W'(flags), W'(4'b1001));
    consume();

    // AND
    issue({LANES{32'hF0F0_F0F0}}, {LANES{32'hFF00_FF00}}, 2'b10, lat);
    check("and_result_lit", result, {LANES{32'hF000_F000}});
    check("and_flags_lit", W'(flags), W'(4'b1000));
    consume();

    // OR and a borrowing / unsigned-carry mix
    issue(pack4(32'h1, 0, 32'h8000_0000, 32'h0F), pack4(32'h2, 0, 32'h1, 32'hF0), 2'b11, lat);
    check("or_lane3_lit", W'(result[3*N +: N]), W'(32'hFF));
    consume();
    issue(pack4(3, 32'h8000_0000, 32'hFFFF_FFFF, 7), pack4(5, 1, 32'hFFFF_FFFF, 2), 2'b01, lat);
    check("sub_borrow_lane0_lit", W'(lane_flags[3:0]), W'(4'b1000));
    check("sub_ovf_lane1_lit", W'(lane_flags[7:4]), W'(4'b0011));
    consume();
    issue({LANES{32'hFFFF_FFFF}}, pack4(1, 2, 0, 32'h8000_0000), 2'b00, lat);
    check("add_carry_flags_lit", W'(flags), W'(4'b1011));
    consume();

    // Back-pressure: DONE holds while new offers are ignored
    issue(pack4(9, 8, 7, 6), pack4(1, 1, 1, 1), 2'b00, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op_a = {LANES{32'hDEAD_BEEF}}; op_b = {LANES{32'h1234_5678}}; control = 2'b11;
      @(negedge clk);
      check("hold_result", result, pack4(10, 9, 8, 7));
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_out_valid", W'(out_valid), W'(1));
    end
    in_valid = 1'b0;
    consume();

    // Reset mid-operation
    @(negedge clk);
    exp_live = 1'b1;
    model(pack4(100, 200, 300, 400), pack4(1, 1, 1, 1), 2'b00);
    op_a = pack4(100, 200, 300, 400); op_b = pack4(1, 1, 1, 1); control = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_live = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_result", result, '0);
    check("midrst_flags", W'(flags), '0);
    @(negedge clk); rst_n = 1'b1;
    issue(pack4(32'hFFFF_FFFF, 2, 4, 6), pack4(1, 3, 5, 7), 2'b00, lat);
    check("post_rst_latency", W'(lat), W'(LANES));
    check("post_rst_result_lit", result, pack4(0, 5, 9, 13));
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 200000);
    $fatal(1, "watchdog");
  end

endmodule
